// File: rtl/stopwatch_ctrl.sv
// Sequencer for a two-digit cascade of external BCD decade counters: turns command pulses into
// counter strobes, prescales clk into count ticks, and stops or wraps at 99.
// Optional macro STOPWATCH_CTRL_BTN_EDGE_EN: commands are raw button levels, synchronized and edge-detected.
module stopwatch_ctrl #(
  parameter int DIV  = 4,
  parameter int PW   = 26,
  parameter int WRAP = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset,
  input  logic       rco_lo,
  input  logic       rco_hi,
  output logic       cnt_clrn,
  output logic       cnt_ldn,
  output logic       cnt_enp,
  output logic       cnt_ent,
  output logic [7:0] load_data,
  output logic [1:0] state,
  output logic       done,
  output logic       wrap_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  state_t        st_q, st_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          ss_cmd, clr_cmd, ld_cmd;
  logic          ld_go;
  logic          run, tick, hold_at_max;

  // rco_lo is wired through only so the cascade stays visible at this boundary.
  logic unused_rco_lo;
  assign unused_rco_lo = rco_lo;

`ifdef STOPWATCH_CTRL_BTN_EDGE_EN
  logic [2:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {start_stop, clear, load};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign {ss_cmd, clr_cmd, ld_cmd} = sync2_q & ~prev_q;
`else
  assign ss_cmd  = start_stop;
  assign clr_cmd = clear;
  assign ld_cmd  = load;
`endif

  assign run         = (st_q == RUN);
  assign tick        = run && (pcnt_q == LAST);
  assign hold_at_max = rco_hi && (WRAP == 0);

  // Only output with a combinational input path: the 99 hold must mask this very tick.
  assign cnt_enp = tick && !hold_at_max;
  assign cnt_ent = run;
  assign done    = (st_q == DONE);
  assign state   = st_q;

  always_comb begin
    st_d   = st_q;
    pcnt_d = pcnt_q;
    ld_go  = 1'b0;
    case (st_q)
      IDLE: begin
        pcnt_d = '0;
        if (!clr_cmd && ld_cmd) begin
          ld_go = 1'b1;
        end else if (!clr_cmd && ss_cmd) begin
          st_d = RUN;
        end
      end
      RUN: begin
        if (clr_cmd) begin
          st_d   = IDLE;
          pcnt_d = '0;
        end else if (ss_cmd) begin
          st_d = PAUSE;
        end else begin
          pcnt_d = tick ? '0 : pcnt_q + PW'(1);
          if (tick && hold_at_max) st_d = DONE;
        end
      end
      PAUSE: begin
        if (clr_cmd) begin
          st_d   = IDLE;
          pcnt_d = '0;
        end else if (ld_cmd) begin
          ld_go = 1'b1;
        end else if (ss_cmd) begin
          st_d = RUN;
        end
      end
      DONE: begin
        pcnt_d = '0;
        if (clr_cmd) begin
          st_d = IDLE;
        end else if (ld_cmd) begin
          ld_go = 1'b1;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q       <= IDLE;
      pcnt_q     <= '0;
      cnt_clrn   <= 1'b0;
      cnt_ldn    <= 1'b1;
      load_data  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      st_q       <= st_d;
      pcnt_q     <= pcnt_d;
      cnt_clrn   <= !clr_cmd;
      cnt_ldn    <= !ld_go;
      wrap_pulse <= (WRAP != 0) && cnt_enp && rco_hi;
      if (ld_go) load_data <= preset;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (stop at 99 and wrap) driving modelled BCD counters,
// checked every cycle against a behavioural stopwatch model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start_stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic [7:0] preset = 8'h00;

  always #5 clk = ~clk;

  // instance a: WRAP=0, instance b: WRAP=1
  logic       clrn_a, ldn_a, enp_a, ent_a, done_a, wrap_a, rco_lo_a, rco_hi_a;
  logic       clrn_b, ldn_b, enp_b, ent_b, done_b, wrap_b, rco_lo_b, rco_hi_b;
  logic [7:0] ld_a, ld_b;
  logic [1:0] st_a, st_b;
  logic [3:0] lo_a = 4'd0, hi_a = 4'd0, lo_b = 4'd0, hi_b = 4'd0;

  stopwatch_ctrl #(.DIV(DIV), .PW(26), .WRAP(0)) dut_a (
    .clk(clk), .clr(clr), .start_stop(start_stop), .clear(clear), .load(load),
    .preset(preset), .rco_lo(rco_lo_a), .rco_hi(rco_hi_a),
    .cnt_clrn(clrn_a), .cnt_ldn(ldn_a), .cnt_enp(enp_a), .cnt_ent(ent_a),
    .load_data(ld_a), .state(st_a), .done(done_a), .wrap_pulse(wrap_a));

  stopwatch_ctrl #(.DIV(DIV), .PW(26), .WRAP(1)) dut_b (
    .clk(clk), .clr(clr), .start_stop(start_stop), .clear(clear), .load(load),
    .preset(preset), .rco_lo(rco_lo_b), .rco_hi(rco_hi_b),
    .cnt_clrn(clrn_b), .cnt_ldn(ldn_b), .cnt_enp(enp_b), .cnt_ent(ent_b),
    .load_data(ld_b), .state(st_b), .done(done_b), .wrap_pulse(wrap_b));

  // External decade counter cascade (clrn > ldn > enable)
  assign rco_lo_a = ent_a && (lo_a == 4'd9);
  assign rco_hi_a = rco_lo_a && (hi_a == 4'd9);
  assign rco_lo_b = ent_b && (lo_b == 4'd9);
  assign rco_hi_b = rco_lo_b && (hi_b == 4'd9);

  function automatic logic [7:0] ctr_next(input logic clrn, input logic ldn, input logic enp,
                                          input logic ent, input logic rlo, input logic [7:0] d,
                                          input logic [3:0] hi, input logic [3:0] lo);
    logic [3:0] h, l;
    h = hi;
    l = lo;
    if (!clrn) return 8'h00;
    if (!ldn) return d;
    if (enp && ent) l = (lo == 4'd9) ? 4'd0 : lo + 4'd1;
    if (enp && rlo) h = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
    return {h, l};
  endfunction

  always @(posedge clk) begin
    {hi_a, lo_a} <= ctr_next(clrn_a, ldn_a, enp_a, ent_a, rco_lo_a, ld_a, hi_a, lo_a);
    {hi_b, lo_b} <= ctr_next(clrn_b, ldn_b, enp_b, ent_b, rco_lo_b, ld_b, hi_b, lo_b);
  end

  // Behavioural model: mode 0 idle, 1 run, 2 pause, 3 done; count as an integer 0..99
  int         m_state[2], m_pcnt[2], m_count[2];
  bit         m_clrn[2], m_ldn[2], m_wrap[2];
  logic [7:0] m_data[2];
  int         checks = 0, errors = 0;

  function automatic bit m_enp(int i);
    return (m_state[i] == 1) && (m_pcnt[i] == DIV - 1) && !(m_count[i] == 99 && i == 0);
  endfunction

  task automatic m_reset(int i);
    m_state[i] = 0; m_pcnt[i] = 0; m_clrn[i] = 1'b0; m_ldn[i] = 1'b1;
    m_wrap[i] = 1'b0; m_data[i] = 8'h00;
  endtask

  task automatic m_step(int i, bit c, bit l, bit s, bit r, logic [7:0] p);
    bit e;
    int old;
    e = m_enp(i);
    old = m_count[i];
    if (!m_clrn[i]) m_count[i] = 0;
    else if (!m_ldn[i]) m_count[i] = int'(m_data[i][7:4]) * 10 + int'(m_data[i][3:0]);
    else if (e) m_count[i] = (old + 1) % 100;
    if (r) begin
      m_reset(i);
      return;
    end
    m_wrap[i] = (i == 1) && e && (old == 99);
    m_clrn[i] = !c;
    m_ldn[i]  = 1'b1;
    case (m_state[i])
      0: begin
        if (!c && l) begin m_ldn[i] = 1'b0; m_data[i] = p; end
        else if (!c && s) begin m_state[i] = 1; m_pcnt[i] = 0; end
      end
      1: begin
        if (c) begin m_state[i] = 0; m_pcnt[i] = 0; end
        else if (s) m_state[i] = 2;
        else begin
          if (m_pcnt[i] == DIV - 1 && i == 0 && old == 99) m_state[i] = 3;
          m_pcnt[i] = (m_pcnt[i] + 1) % DIV;
        end
      end
      2: begin
        if (c) begin m_state[i] = 0; m_pcnt[i] = 0; end
        else if (l) begin m_ldn[i] = 1'b0; m_data[i] = p; end
        else if (s) m_state[i] = 1;
      end
      default: begin
        m_pcnt[i] = 0;
        if (c) m_state[i] = 0;
        else if (l) begin m_ldn[i] = 1'b0; m_data[i] = p; m_state[i] = 0; end
      end
    endcase
  endtask

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(int i, logic [1:0] st, logic clrn, logic ldn, logic enp, logic ent,
                          logic dn, logic wp, logic [7:0] ld, logic [3:0] hi, logic [3:0] lo);
    logic [7:0] bcd;
    bcd = 8'((m_count[i] / 10) * 16 + (m_count[i] % 10));
    chk("state", i, 32'(st), 32'(m_state[i]));
    chk("cnt_clrn", i, 32'(clrn), 32'(m_clrn[i]));
    chk("cnt_ldn", i, 32'(ldn), 32'(m_ldn[i]));
    chk("cnt_enp", i, 32'(enp), 32'(m_enp(i)));
    chk("cnt_ent", i, 32'(ent), 32'(m_state[i] == 1));
    chk("done", i, 32'(dn), 32'(m_state[i] == 3));
    chk("wrap_pulse", i, 32'(wp), 32'(m_wrap[i]));
    chk("load_data", i, 32'(ld), 32'(m_data[i]));
    chk("count", i, 32'({hi, lo}), 32'(bcd));
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge, then advance the model.
  task automatic cyc(bit c, bit l, bit s, bit r, logic [7:0] p);
    clear = c; load = l; start_stop = s; preset = p;
    if (r && !clr) begin
      m_reset(0);
      m_reset(1);
    end
    clr = r;
    @(negedge clk);
    cmp_inst(0, st_a, clrn_a, ldn_a, enp_a, ent_a, done_a, wrap_a, ld_a, hi_a, lo_a);
    cmp_inst(1, st_b, clrn_b, ldn_b, enp_b, ent_b, done_b, wrap_b, ld_b, hi_b, lo_b);
    m_step(0, c, l, s, r, p);
    m_step(1, c, l, s, r, p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_reset(i);
      m_count[i] = 0;
    end
    @(posedge clk);
    #1;

    // reset held three cycles, then release
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("rst_clrn_low", 0, 32'(clrn_a), 32'd0);
    idle_n(1);
    chk("post_rst_clrn", 0, 32'(clrn_a), 32'd1);
    chk("post_rst_state", 0, 32'(st_a), 32'd0);
    chk("post_rst_count", 0, 32'({hi_a, lo_a}), 32'h00);

    // run 40 cycles: ten ticks
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("run_state", 0, 32'(st_a), 32'd1);
    idle_n(40);
    chk("model_cnt10", 0, 32'(m_count[0]), 32'd10);
    chk("run40_count", 0, 32'({hi_a, lo_a}), 32'h10);
    chk("run40_count", 1, 32'({hi_b, lo_b}), 32'h10);

    // pause at pcnt=2, resume, first tick one cycle later
    idle_n(2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("pause_state", 0, 32'(st_a), 32'd2);
    chk("model_pcnt2", 0, 32'(m_pcnt[0]), 32'd2);
    idle_n(3);
    chk("pause_frozen", 0, 32'({hi_a, lo_a}), 32'h10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle_n(1);
    chk("resume_no_tick", 0, 32'({hi_a, lo_a}), 32'h10);
    idle_n(1);
    chk("resume_tick", 0, 32'({hi_a, lo_a}), 32'h11);

    // load 98, run to 99 and beyond
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idle_n(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h98);
    chk("load_ldn_low", 0, 32'(ldn_a), 32'd0);
    idle_n(1);
    chk("loaded_98", 0, 32'({hi_a, lo_a}), 32'h98);
    chk("loaded_98", 1, 32'({hi_b, lo_b}), 32'h98);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle_n(4);
    chk("count_99", 0, 32'({hi_a, lo_a}), 32'h99);
    chk("model_cnt99", 1, 32'(m_count[1]), 32'd99);
    idle_n(4);
    chk("limit_state", 0, 32'(st_a), 32'd3);
    chk("limit_done", 0, 32'(done_a), 32'd1);
    chk("limit_hold", 0, 32'({hi_a, lo_a}), 32'h99);
    chk("wrap_state", 1, 32'(st_b), 32'd1);
    chk("wrap_count", 1, 32'({hi_b, lo_b}), 32'h00);
    chk("wrap_pulse_hi", 1, 32'(wrap_b), 32'd1);
    idle_n(1);

    // all three commands together while running
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle_n(5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
    chk("prio_state", 0, 32'(st_a), 32'd0);
    chk("prio_clrn", 0, 32'(clrn_a), 32'd0);
    chk("prio_ldn", 0, 32'(ldn_a), 32'd1);
    idle_n(1);
    chk("prio_count", 1, 32'({hi_b, lo_b}), 32'h00);

    // asynchronous reset mid-run
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle_n(5);
    clr = 1'b1;
    m_reset(0);
    m_reset(1);
    #1;
    chk("async_state", 0, 32'(st_a), 32'd0);
    chk("async_clrn", 0, 32'(clrn_a), 32'd0);
    chk("async_ent", 0, 32'(ent_a), 32'd0);
    chk("async_enp", 0, 32'(enp_a), 32'd0);
    chk("async_ld", 1, 32'(ld_b), 32'h00);
    chk("async_ldn", 1, 32'(ldn_b), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle_n(2);

    // randomized commands, occasional reset
    for (int k = 0; k < 3000; k++) begin
      bit c, l, s, r;
      logic [3:0] ph, pl;
      r  = ($urandom_range(0, 399) == 0);
      c  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 11) == 0);
      s  = ($urandom_range(0, 7) == 0);
      ph = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(0, 9));
      pl = 4'($urandom_range(0, 9));
      cyc(c, l, s, r, {ph, pl});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencer for a two-digit cascade of the team's synchronous BCD decade counters (active-low sync clear `clrn`, active-low sync load `ldn`, count enables `enp`/`ent`, ripple-carry `rco`).
- Turns single-cycle start/stop, clear and load commands into counter control strobes.
- Divides `clk` into a count tick, and stops or wraps the count at 99.
- Counters are external. Low digit gets `ent = cnt_ent`; high digit gets `ent = rco_lo`. `enp`, `clrn`, `ldn` are shared.

Parameters:
- DIV, 4, clk cycles per count tick (>=2; board build overrides to 50000000).
- PW, 26, prescaler width; must satisfy 2^PW >= DIV.
- WRAP, 0, 0 = stop in DONE at 99; 1 = roll 99->00 and keep running.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-high reset.
- start_stop  input  1  command pulse: toggle run/pause.
- clear  input  1  command pulse: zero counters, go IDLE.
- load  input  1  command pulse: load preset.
- preset  input  8  BCD preset: [7:4] high digit, [3:0] low digit.
- rco_lo  input  1  rco of low-digit counter.
- rco_hi  input  1  rco of high-digit counter.
- cnt_clrn  output  1  to both counters' clrn.
- cnt_ldn  output  1  to both counters' ldn.
- cnt_enp  output  1  to both counters' enp.
- cnt_ent  output  1  to low counter's ent.
- load_data  output  8  to counters' data_in (high/low nibble).
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- done  output  1  high while in DONE.
- wrap_pulse  output  1  one-cycle strobe on a 99->00 rollover (WRAP=1 only).

Behaviour:
- Reset (clr high, asynchronous):
  - state=IDLE, prescaler pcnt=0, load_data=0.
  - cnt_clrn=0, so counters clear on every clk edge while clr is held.
  - cnt_ldn=1, cnt_enp=0, cnt_ent=0, done=0, wrap_pulse=0.
  - First edge after release sets cnt_clrn=1.
- Command priority in the same cycle: clear > load > start_stop. Lower-priority commands that cycle are dropped.
- cnt_clrn and cnt_ldn:
  - Registered, active low for exactly one cycle, asserted the cycle after the command.
  - load_data registers preset on the same edge that drives cnt_ldn low, and holds until the next load.
- cnt_ent = (state==RUN), registered state decode.
- cnt_enp = (state==RUN) && pcnt==DIV-1 && !(rco_hi && WRAP==0). This is the only output with a combinational input path (rco_hi).
- IDLE:
  - start_stop -> RUN with pcnt=0.
  - clear -> clear pulse, stay in IDLE.
  - load -> load pulse, stay in IDLE.
- RUN:
  - pcnt increments each cycle, wrapping DIV-1 -> 0. The counters advance at the end of the pcnt==DIV-1 cycle.
  - start_stop -> PAUSE; pcnt holds.
  - clear -> clear pulse, IDLE, pcnt=0.
  - load is ignored.
  - On a tick with rco_hi=1 (count 99) and WRAP=0: cnt_enp is masked and next state is DONE, so the count stays at 99.
  - On a tick with rco_hi=1 and WRAP=1: the count rolls to 00, wrap_pulse=1 for the next cycle, state stays RUN.
- PAUSE:
  - cnt_enp=0, cnt_ent=0, pcnt frozen.
  - start_stop -> RUN, resuming from the frozen pcnt.
  - clear -> clear pulse, IDLE, pcnt=0.
  - load -> load pulse, stay in PAUSE.
- DONE:
  - done=1; enables low.
  - start_stop ignored.
  - clear -> clear pulse, IDLE.
  - load -> load pulse, IDLE.
- Reset asserted mid-operation overrides everything immediately, including a pending clear or load pulse.
- rco_lo is used only for cascade wiring checks and does not affect the state machine. It is kept as a port for bench visibility.

Optional Feature:
- Macro: STOPWATCH_CTRL_BTN_EDGE_EN.
- Defined:
  - start_stop, clear and load are raw button levels.
  - Each passes through a 2-flop synchronizer plus rising-edge detector; the detected edge acts as the command pulse.
  - This adds 2 cycles of command latency.
  - A level held high produces exactly one command.
  - Synchronizer flops reset to 0.
- Undefined: inputs are treated as clean single-cycle pulses and sampled directly. A held level repeats the command every cycle.

Test Plan:
- Reset then idle: clr high 3 cycles, release -> cnt_clrn=0 during reset and 1 from the first post-reset cycle; state=00; count 00.
- Run/tick: DIV=4, start_stop pulse -> state=01 next cycle, cnt_enp high 1 of every 4 cycles; after 40 cycles count = 10 (high digit 1, low digit 0).
- Pause/resume: start_stop at pcnt=2 -> PAUSE with count frozen; a second start_stop resumes and the first tick arrives 1 cycle later (pcnt 2->3).
- Stop at limit: WRAP=0, load preset 8'h98 in IDLE -> cnt_ldn low 1 cycle, count 98. Start -> count 99 after 4 cycles; at the next tick enp stays masked, state=11, done=1, count stays 99.
- Wrap: WRAP=1, preset 8'h99, start -> after the first tick count 00, wrap_pulse high 1 cycle, state stays 01.
- Priority and mid-run: clear+load+start_stop in the same cycle while in RUN -> only cnt_clrn pulses, state=00, count 00. Assert clr during RUN -> outputs at reset values within the same cycle.
